cordic_engine: RTL and testbench

CORDIC_ENGINE -- requirements
Module: cordic_engine

---
 rtl/cordic_engine.sv | 194 +++++++++++++++++++
 tb/tb_cordic_engine.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_engine.sv
// Iterative CORDIC engine: rotation and vectoring modes, one micro-rotation
// per clock, valid/ready on both sides, outputs carry the CORDIC gain.
module cordic_engine #(
  parameter int DATA_W = 16,
  parameter int ITERS  = 14,
  parameter int GUARD  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_y,
  input  logic [DATA_W-1:0] in_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_x,
  output logic [DATA_W-1:0] out_y,
  output logic [DATA_W-1:0] out_z,
  output logic              out_mode,
  output logic              busy
);

  localparam int XW = DATA_W + 2 * GUARD;
  localparam int ZW = DATA_W + GUARD;
  localparam int CW = $clog2(ITERS + 1);
  localparam real PI = 3.14159265358979323846;

  localparam logic signed [XW:0] RND =
    (XW+1)'(1 << (GUARD - 1));
  localparam logic [ZW-1:0] ZRND =
    ZW'(1 << (GUARD - 1));
  localparam logic signed [XW:0] SMAX =
    (XW+1)'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [XW:0] SMIN = ~SMAX;

  typedef enum logic [2:0] {
    IDLE, PRE, ITER, POST, DONE
  } state_t;

  function automatic logic [ZW-1:0] atan_val(
    input int i
  );
    real a;
    a = $atan(1.0 / (2.0 ** i)) * (2.0 ** ZW)
        / (2.0 * PI);
    return ZW'($rtoi(a + 0.5));
  endfunction

  function automatic logic [DATA_W-1:0] sat(
    input logic signed [XW:0] v
  );
    if (v > SMAX)
      return SMAX[DATA_W-1:0];
    else if (v < SMIN)
      return SMIN[DATA_W-1:0];
    else
      return v[DATA_W-1:0];
  endfunction

  state_t                  state;
  logic                    mode_r;
  logic signed [XW-1:0]    x_r;
  logic signed [XW-1:0]    y_r;
  logic        [ZW-1:0]    z_r;
  logic        [CW-1:0]    cnt;

  // arctangent ROM, fixed at elaboration
  logic [ZW-1:0] atan_rom [2**CW];
  for (genvar g = 0; g < 2**CW; g++) begin : g_rom
    localparam logic [ZW-1:0] A = atan_val(g);
    assign atan_rom[g] = A;
  end

  logic                 accept;
  logic signed [XW-1:0] x_in;
  logic signed [XW-1:0] y_in;
  logic        [ZW-1:0] z_in;
  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;
  logic                 dpos;
  logic signed [XW:0]   xq;
  logic signed [XW:0]   yq;
  logic        [ZW-1:0] zq;

  assign in_ready = (state == IDLE) ||
                    (state == DONE && out_ready);
  assign busy   = (state != IDLE);
  assign accept = in_valid && in_ready;

  assign x_in = {{GUARD{in_x[DATA_W-1]}},
                 in_x, {GUARD{1'b0}}};
  assign y_in = {{GUARD{in_y[DATA_W-1]}},
                 in_y, {GUARD{1'b0}}};
  assign z_in = {in_z, {GUARD{1'b0}}};

  assign xs   = x_r >>> cnt;
  assign ys   = y_r >>> cnt;
  assign dpos = mode_r ? y_r[XW-1] : !z_r[ZW-1];

  assign xq = ($signed({x_r[XW-1], x_r}) + RND)
              >>> GUARD;
  assign yq = ($signed({y_r[XW-1], y_r}) + RND)
              >>> GUARD;
  assign zq = z_r + ZRND;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mode_r    <= 1'b0;
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
      out_mode  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mode_r <= in_mode;
            x_r    <= x_in;
            y_r    <= y_in;
            z_r    <= z_in;
            state  <= PRE;
          end
        end
        PRE: begin
          cnt   <= '0;
          state <= ITER;
          if (mode_r) begin
            if (x_r[XW-1]) begin
              x_r <= -x_r;
              y_r <= -y_r;
              z_r <= {1'b1, {(ZW-1){1'b0}}};
            end else begin
              z_r <= '0;
            end
          end else if (z_r[ZW-1] ^ z_r[ZW-2]) begin
            // fold [90,270) into the convergence range
            x_r <= -x_r;
            y_r <= -y_r;
            z_r <= {~z_r[ZW-1], z_r[ZW-2:0]};
          end
        end
        ITER: begin
          if (dpos) begin
            x_r <= x_r - ys;
            y_r <= y_r + xs;
            z_r <= z_r - atan_rom[cnt];
          end else begin
            x_r <= x_r + ys;
            y_r <= y_r - xs;
            z_r <= z_r + atan_rom[cnt];
          end
          if (cnt == CW'(ITERS - 1)) begin
            cnt   <= '0;
            state <= POST;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        POST: begin
          out_x     <= sat(xq);
          out_y     <= sat(yq);
          out_z     <= DATA_W'(zq >> GUARD);
          out_mode  <= mode_r;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              mode_r <= in_mode;
              x_r    <= x_in;
              y_r    <= y_in;
              z_r    <= z_in;
              state  <= PRE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Directed bench for cordic_engine with an expected-result queue
// filled on request and drained on each result.
module tb_cordic_engine;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_mode = 1'b0;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_y = '0;
  logic [W-1:0] in_z = '0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_x;
  logic [W-1:0] out_y;
  logic [W-1:0] out_z;
  logic         out_mode;
  logic         busy;

  cordic_engine #(
    .DATA_W(16),
    .ITERS (14),
    .GUARD (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_z     (in_z),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x    (out_x),
    .out_y    (out_y),
    .out_z    (out_z),
    .out_mode (out_mode),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // tolerance < 0 means that field is not checked
  typedef struct {
    string        tag;
    logic         m;
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    logic [W-1:0] ez;
    int           tx;
    int           ty;
    int           tz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   acc_cyc = 0;

  function automatic exp_t mk(
    string tag, logic m,
    logic [W-1:0] ex, logic [W-1:0] ey,
    logic [W-1:0] ez,
    int tx, int ty, int tz
  );
    exp_t e;
    e.tag = tag; e.m = m;
    e.ex = ex; e.ey = ey; e.ez = ez;
    e.tx = tx; e.ty = ty; e.tz = tz;
    return e;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_tol(string tag,
                         logic [W-1:0] obs,
                         logic [W-1:0] exp,
                         int tol);
    logic [W-1:0] d;
    int           sd;
    d  = obs - exp;
    sd = int'($signed(d));
    n_cmp++;
    assert ((sd <= tol) && (sd >= -tol)) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h +/-%0d",
             tag, obs, exp, tol);
    end
  endtask

  task automatic send(logic m, logic [W-1:0] x,
                      logic [W-1:0] y,
                      logic [W-1:0] z,
                      bit push, exp_t e);
    int n;
    if (push) sb.push_back(e);
    in_mode  = m;
    in_x     = x;
    in_y     = y;
    in_z     = z;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({e.tag, "_ready"}, int'(in_ready), 1);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(string tag);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_seen"}, int'(out_valid), 1);
    chk({tag, "_lat"}, cyc - acc_cyc, 16);
  endtask

  task automatic cmp_front();
    exp_t e;
    chk("sb_nonempty", int'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.tx >= 0)
        chk_tol({e.tag, "_x"}, out_x, e.ex, e.tx);
      if (e.ty >= 0)
        chk_tol({e.tag, "_y"}, out_y, e.ey, e.ty);
      if (e.tz >= 0)
        chk_tol({e.tag, "_z"}, out_z, e.ez, e.tz);
      chk({e.tag, "_mode"}, int'(out_mode), int'(e.m));
    end
  endtask

  task automatic collect(string tag);
    out_ready = 1'b1;
    wait_valid(tag);
    cmp_front();
    @(posedge clk); #1;
    chk({tag, "_fall"}, int'(out_valid), 0);
  endtask

  exp_t e;
  exp_t none;
  logic [W-1:0] hx;
  logic [W-1:0] hy;
  logic [W-1:0] hz;
  int seen;

  initial begin
    none = mk("rst_op", 1'b0, 16'h0, 16'h0, 16'h0,
              -1, -1, -1);

    // reset state
    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_x", int'(out_x), 0);
    chk("rst_out_y", int'(out_y), 0);
    chk("rst_out_z", int'(out_z), 0);
    chk("rst_out_mode", int'(out_mode), 0);
    @(negedge clk);
    reset = 1'b0;

    // rotation, first accept right after reset
    e = mk("rot90", 1'b0, 16'h0000, 16'h4000,
           16'h0000, 4, 4, 8);
    send(1'b0, 16'h26DD, 16'h0000, 16'h4000, 1, e);
    chk("rot90_busy", int'(busy), 1);
    collect("rot90");

    e = mk("rot180", 1'b0, 16'hC000, 16'h0000,
           16'h0000, 4, 4, 8);
    send(1'b0, 16'h26DD, 16'h0000, 16'h8000, 1, e);
    collect("rot180");

    e = mk("rot270", 1'b0, 16'h0000, 16'hC000,
           16'h0000, 4, 4, 8);
    send(1'b0, 16'h26DD, 16'h0000, 16'hC000, 1, e);
    collect("rot270");

    e = mk("rot0", 1'b0, 16'h4000, 16'h0000,
           16'h0000, 4, 4, 8);
    send(1'b0, 16'h26DD, 16'h0000, 16'h0000, 1, e);
    collect("rot0");

    // vectoring
    e = mk("vec45", 1'b1, 16'h4A86, 16'h0000,
           16'h2000, 4, -1, 8);
    send(1'b1, 16'h2000, 16'h2000, 16'h1234, 1, e);
    collect("vec45");

    e = mk("vec180", 1'b1, 16'h34B2, 16'h0000,
           16'h8000, 4, -1, 8);
    send(1'b1, 16'hE000, 16'h0000, 16'h0000, 1, e);
    collect("vec180");

    // saturation
    e = mk("sat", 1'b0, 16'h7FFF, 16'h7FFF,
           16'h0000, 0, 0, -1);
    send(1'b0, 16'h7FFF, 16'h7FFF, 16'h0000, 1, e);
    collect("sat");

    // back-pressure with a pending request
    out_ready = 1'b0;
    e = mk("bp_a", 1'b0, 16'h0000, 16'h4000,
           16'h0000, 4, 4, 8);
    send(1'b0, 16'h26DD, 16'h0000, 16'h4000, 1, e);
    wait_valid("bp_a");
    hx = out_x;
    hy = out_y;
    hz = out_z;
    e = mk("bp_b", 1'b0, 16'hC000, 16'h0000,
           16'h0000, 4, 4, 8);
    sb.push_back(e);
    in_mode  = 1'b0;
    in_x     = 16'h26DD;
    in_y     = 16'h0000;
    in_z     = 16'h8000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_x", int'(out_x), int'(hx));
      chk("bp_hold_y", int'(out_y), int'(hy));
      chk("bp_hold_z", int'(out_z), int'(hz));
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    cmp_front();
    out_ready = 1'b1;
    #1;
    chk("bp_ready_on_hs", int'(in_ready), 1);
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    chk("bp_hs_fall", int'(out_valid), 0);
    chk("bp_hs_busy", int'(busy), 1);
    collect("bp_b");

    // reset during iteration 5
    send(1'b0, 16'h26DD, 16'h0000, 16'h4000, 0, none);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_out_x", int'(out_x), 0);
    chk("mid_rst_out_y", int'(out_y), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("mid_rst_no_valid", seen, 0);
    chk("mid_rst_idle", int'(busy), 0);
    chk("mid_rst_sb_empty", sb.size(), 0);

    e = mk("post_rst", 1'b0, 16'hC000, 16'h0000,
           16'h0000, 4, 4, 8);
    send(1'b0, 16'h26DD, 16'h0000, 16'h8000, 1, e);
    collect("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
